// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - parametrised multi-mode PWM period counter with shadowed config
module pwm_period_counter #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  MClk,
    input  logic                  MResetN,
    input  logic                  Enable,
    input  logic [1:0]            Mode,
    input  logic [WIDTH-1:0]      MaxCount,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [WIDTH-1:0]      Count,
    output logic                  Dir,
    output logic                  Tick,
    output logic                  Wrap,
    output logic                  Done
);

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_UPDOWN  = 2'd2;

    // Shadow copies: the running period only ever sees these.
    logic [WIDTH-1:0]      sh_max;
    logic [1:0]            sh_mode;
    logic [PRESCALE_W-1:0] sh_pre;
    logic [PRESCALE_W-1:0] pre_cnt;

    logic                  step;
    logic [WIDTH:0]        cnt_inc;
    logic                  at_end;
    logic [WIDTH-1:0]      nxt_count;
    logic                  nxt_dir;
    logic                  nxt_done;
    logic                  nxt_wrap;
    logic                  reload;

    // Next count/direction/flags for the current step; one extra bit keeps M = 0 from underflowing.
    always_comb begin
        step      = (pre_cnt == sh_pre);
        cnt_inc   = {1'b0, Count} + (WIDTH+1)'(1);
        at_end    = (cnt_inc >= {1'b0, sh_max});
        nxt_count = Count;
        nxt_dir   = Dir;
        nxt_done  = Done;
        nxt_wrap  = 1'b0;
        reload    = 1'b0;
        if (step) begin
            case (sh_mode)
                MODE_ONESHOT: begin
                    if (at_end) begin
                        nxt_done = 1'b1;
                    end else begin
                        nxt_count = cnt_inc[WIDTH-1:0];
                    end
                end
                MODE_UPDOWN: begin
                    if (!Dir) begin
                        if (Count == sh_max) begin
                            if (sh_max <= WIDTH'(1)) begin
                                // Degenerate top: no down phase, close the period here.
                                nxt_count = '0;
                                nxt_wrap  = 1'b1;
                                reload    = 1'b1;
                            end else begin
                                nxt_dir   = 1'b1;
                                nxt_count = sh_max - WIDTH'(1);
                            end
                        end else begin
                            nxt_count = cnt_inc[WIDTH-1:0];
                        end
                    end else begin
                        if (Count <= WIDTH'(1)) begin
                            nxt_count = '0;
                            nxt_dir   = 1'b0;
                            nxt_wrap  = 1'b1;
                            reload    = 1'b1;
                        end else begin
                            nxt_count = Count - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // Periodic; the reserved encoding falls here too.
                    if (at_end) begin
                        nxt_count = '0;
                        nxt_wrap  = 1'b1;
                        reload    = 1'b1;
                    end else begin
                        nxt_count = cnt_inc[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    // State register: async reset, Enable-low clear with shadow load, otherwise step-driven update.
    always_ff @(posedge MClk or negedge MResetN) begin
        if (!MResetN) begin
            Count   <= '0;
            Dir     <= 1'b0;
            Tick    <= 1'b0;
            Wrap    <= 1'b0;
            Done    <= 1'b0;
            pre_cnt <= '0;
            sh_max  <= '0;
            sh_mode <= '0;
            sh_pre  <= '0;
        end else if (!Enable) begin
            Count   <= '0;
            Dir     <= 1'b0;
            Tick    <= 1'b0;
            Wrap    <= 1'b0;
            Done    <= 1'b0;
            pre_cnt <= '0;
            sh_max  <= MaxCount;
            sh_mode <= Mode;
            sh_pre  <= Prescale;
        end else begin
            pre_cnt <= step ? '0 : pre_cnt + PRESCALE_W'(1);
            Tick    <= step;
            Wrap    <= nxt_wrap;
            Count   <= nxt_count;
            Dir     <= nxt_dir;
            Done    <= nxt_done;
            if (reload) begin
                sh_max  <= MaxCount;
                sh_mode <= Mode;
                sh_pre  <= Prescale;
            end
        end
    end

endmodule

// File: tb/tb_pwm_period_counter.sv
// tb/tb_pwm_period_counter.sv - scoreboard bench for pwm_period_counter
module tb_pwm_period_counter;

    localparam int WIDTH      = 16;
    localparam int PRESCALE_W = 8;
    localparam int BUDGET     = 50;

    logic                  MClk;
    logic                  MResetN;
    logic                  Enable;
    logic [1:0]            Mode;
    logic [WIDTH-1:0]      MaxCount;
    logic [PRESCALE_W-1:0] Prescale;
    logic [WIDTH-1:0]      Count;
    logic                  Dir;
    logic                  Tick;
    logic                  Wrap;
    logic                  Done;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             dir;
        logic             wrap;
        logic             done;
        int               gap;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;

    pwm_period_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .MClk     (MClk),
        .MResetN  (MResetN),
        .Enable   (Enable),
        .Mode     (Mode),
        .MaxCount (MaxCount),
        .Prescale (Prescale),
        .Count    (Count),
        .Dir      (Dir),
        .Tick     (Tick),
        .Wrap     (Wrap),
        .Done     (Done)
    );

    initial MClk = 1'b0;
    always #5 MClk = ~MClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int c, input logic d, input logic w, input logic dn, input int gap);
        exp_t e;
        e.count = WIDTH'(c);
        e.dir   = d;
        e.wrap  = w;
        e.done  = dn;
        e.gap   = gap;
        q.push_back(e);
    endtask

    // Waits for each expected step (Tick seen at a falling edge) and compares it.
    task automatic drain(input string tag);
        exp_t e;
        int   n;
        while (q.size() > 0) begin
            e = q.pop_front();
            n = 0;
            do begin
                @(negedge MClk);
                n++;
            end while (!Tick && n < BUDGET);
            check({tag, "_tick_seen"}, 32'(Tick), 32'd1);
            if (Tick) begin
                check({tag, "_count"}, 32'(Count), 32'(e.count));
                check({tag, "_dir"},   32'(Dir),   32'(e.dir));
                check({tag, "_wrap"},  32'(Wrap),  32'(e.wrap));
                check({tag, "_done"},  32'(Done),  32'(e.done));
                if (e.gap != 0) check({tag, "_gap"}, 32'(n), 32'(e.gap));
            end
        end
    endtask

    task automatic start_run(input logic [1:0] m, input int mx, input int pre);
        Enable   = 1'b0;
        Mode     = m;
        MaxCount = WIDTH'(mx);
        Prescale = PRESCALE_W'(pre);
        @(negedge MClk);
        Enable   = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        MResetN  = 1'b0;
        Enable   = 1'b0;
        Mode     = 2'd0;
        MaxCount = '0;
        Prescale = '0;

        // Reset state
        @(negedge MClk);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_dir",   32'(Dir),   32'd0);
        check("rst_tick",  32'(Tick),  32'd0);
        check("rst_wrap",  32'(Wrap),  32'd0);
        check("rst_done",  32'(Done),  32'd0);
        MResetN = 1'b1;
        @(negedge MClk);

        // One-shot, M = 5
        start_run(2'd0, 5, 0);
        for (int i = 1; i <= 4; i++) push(i, 1'b0, 1'b0, 1'b0, 1);
        push(4, 1'b0, 1'b0, 1'b1, 1);
        push(4, 1'b0, 1'b0, 1'b1, 1);
        drain("oneshot5");
        Enable = 1'b0;
        @(negedge MClk);
        check("dis_count", 32'(Count), 32'd0);
        check("dis_done",  32'(Done),  32'd0);

        // Periodic, M = 4, Prescale = 2
        start_run(2'd1, 4, 2);
        for (int p = 0; p < 2; p++) begin
            push(1, 1'b0, 1'b0, 1'b0, 3);
            push(2, 1'b0, 1'b0, 1'b0, 3);
            push(3, 1'b0, 1'b0, 1'b0, 3);
            push(0, 1'b0, 1'b1, 1'b0, 3);
        end
        drain("per4");
        @(negedge MClk);
        check("per4_wrap_one_cycle", 32'(Wrap), 32'd0);
        check("per4_tick_one_cycle", 32'(Tick), 32'd0);

        // Up/down, M = 3
        start_run(2'd2, 3, 0);
        for (int p = 0; p < 2; p++) begin
            push(1, 1'b0, 1'b0, 1'b0, 1);
            push(2, 1'b0, 1'b0, 1'b0, 1);
            push(3, 1'b0, 1'b0, 1'b0, 1);
            push(2, 1'b1, 1'b0, 1'b0, 1);
            push(1, 1'b1, 1'b0, 1'b0, 1);
            push(0, 1'b0, 1'b1, 1'b0, 1);
        end
        drain("ud3");

        // Up/down, M = 1
        start_run(2'd2, 1, 0);
        for (int p = 0; p < 2; p++) begin
            push(1, 1'b0, 1'b0, 1'b0, 1);
            push(0, 1'b0, 1'b1, 1'b0, 1);
        end
        drain("ud1");

        // Up/down, M = 0
        start_run(2'd2, 0, 0);
        for (int p = 0; p < 3; p++) push(0, 1'b0, 1'b1, 1'b0, 1);
        drain("ud0");

        // Shadowing: MaxCount then Mode changed mid-period
        start_run(2'd1, 8, 0);
        for (int i = 1; i <= 3; i++) push(i, 1'b0, 1'b0, 1'b0, 1);
        drain("sh_a");
        MaxCount = WIDTH'(3);
        for (int i = 4; i <= 7; i++) push(i, 1'b0, 1'b0, 1'b0, 1);
        push(0, 1'b0, 1'b1, 1'b0, 1);
        push(1, 1'b0, 1'b0, 1'b0, 1);
        drain("sh_b");
        Mode = 2'd2;
        push(2, 1'b0, 1'b0, 1'b0, 1);
        push(0, 1'b0, 1'b1, 1'b0, 1);
        push(1, 1'b0, 1'b0, 1'b0, 1);
        push(2, 1'b0, 1'b0, 1'b0, 1);
        push(3, 1'b0, 1'b0, 1'b0, 1);
        push(2, 1'b1, 1'b0, 1'b0, 1);
        push(1, 1'b1, 1'b0, 1'b0, 1);
        push(0, 1'b0, 1'b1, 1'b0, 1);
        drain("sh_c");

        // Asynchronous reset mid-count
        start_run(2'd1, 8, 0);
        for (int i = 1; i <= 3; i++) push(i, 1'b0, 1'b0, 1'b0, 1);
        drain("ar_pre");
        @(posedge MClk);
        #2 MResetN = 1'b0;
        #1;
        check("ar_count", 32'(Count), 32'd0);
        check("ar_tick",  32'(Tick),  32'd0);
        check("ar_dir",   32'(Dir),   32'd0);
        check("ar_done",  32'(Done),  32'd0);
        Enable   = 1'b0;
        Mode     = 2'd1;
        MaxCount = WIDTH'(2);
        @(negedge MClk);
        MResetN = 1'b1;
        @(negedge MClk);
        Enable = 1'b1;
        push(1, 1'b0, 1'b0, 1'b0, 1);
        push(0, 1'b0, 1'b1, 1'b0, 1);
        push(1, 1'b0, 1'b0, 1'b0, 1);
        drain("ar_post");

        // One-shot boundaries
        start_run(2'd0, 0, 0);
        push(0, 1'b0, 1'b0, 1'b1, 1);
        push(0, 1'b0, 1'b0, 1'b1, 1);
        drain("os0");
        start_run(2'd0, 1, 0);
        push(0, 1'b0, 1'b0, 1'b1, 1);
        push(0, 1'b0, 1'b0, 1'b1, 1);
        drain("os1");

        // Reserved mode behaves as periodic
        start_run(2'd3, 2, 0);
        for (int p = 0; p < 2; p++) begin
            push(1, 1'b0, 1'b0, 1'b0, 1);
            push(0, 1'b0, 1'b1, 1'b0, 1);
        end
        drain("mode3");

        Enable = 1'b0;
        @(negedge MClk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_period_counter.md
Name: pwm_period_counter

Overview:
- Parametrised, multi-mode period counter; successor to the single-width, one-shot PWM counter.
- Adds:
  - configurable width and prescaler;
  - one-shot, periodic (edge-aligned) and up/down (centre-aligned) modes;
  - shadowed MaxCount, Mode and Prescale that reload only at period boundaries;
  - a per-step tick and a wrap pulse.
- Feeds the PWM compare stage, which compares Count against duty thresholds.

Parameters:
- WIDTH, 16, counter and MaxCount width in bits (2..32)
- PRESCALE_W, 8, prescaler width in bits (1..16)

Ports:
- MClk  input  1  system clock; all logic is on the rising edge
- MResetN  input  1  asynchronous, active-low reset
- Enable  input  1  run when 1; synchronous clear when 0
- Mode  input  2  0 = one-shot, 1 = periodic, 2 = up/down, 3 = reserved (behaves as 1)
- MaxCount  input  WIDTH  period length M in count steps
- Prescale  input  PRESCALE_W  counter steps once every Prescale+1 MClk cycles
- Count  output  WIDTH  current count value
- Dir  output  1  0 = counting up, 1 = counting down (up/down mode only)
- Tick  output  1  one-cycle pulse on each count step
- Wrap  output  1  one-cycle pulse at the end of each period
- Done  output  1  one-shot complete; held until Enable = 0

Behaviour:
- Reset (MResetN = 0, asynchronous, takes effect immediately, including mid-operation):
  - Count = 0, Dir = 0, Tick = 0, Wrap = 0, Done = 0.
  - Prescaler count = 0.
  - Shadow M, Mode and Prescale = 0.
- Enable = 0 (checked at each edge):
  - Count, Dir, Tick, Wrap, Done and the prescaler clear to 0.
  - Shadows load from MaxCount, Mode and Prescale every cycle.
  - Deasserting Enable mid-period therefore aborts the period; reasserting starts from 0 with the current inputs.
- Step event, with Enable = 1:
  - The prescaler counts 0..shadowPrescale; a step occurs on the cycle it equals shadowPrescale, and the prescaler then returns to 0.
  - Prescale = 0 gives a step every cycle.
  - The first step occurs shadowPrescale+1 cycles after Enable rises.
- Output timing: all outputs are registered and update on the step edge; Tick and Wrap are high for exactly the one cycle following that edge.
- Arithmetic: compare Count+1 against M in WIDTH+1 bits so that M = 0 never underflows.
- Mode 0, one-shot:
  - On a step, if Count+1 >= M, set Done = 1 and hold Count; otherwise Count <= Count+1.
  - Count runs 0..M-1, then Done rises on the next step. Example: M = 3 gives Done high 3 steps after the start.
  - M = 0 or M = 1: Done rises on the first step and Count stays 0.
  - Wrap is never asserted; shadows do not reload while running.
- Mode 1/3, periodic:
  - Count runs 0..M-1.
  - On the step where Count = M-1: Count <= 0, Wrap pulses, shadows reload.
  - Period is M steps. M = 0 or 1: Count stays 0 and Wrap pulses on every step.
  - Done stays 0.
- Mode 2, up/down:
  - Up phase (Dir = 0): on the step where Count = M, Dir <= 1 and Count <= M-1.
  - Down phase (Dir = 1): on the step where Count = 1, Count <= 0, Dir <= 0, Wrap pulses, shadows reload.
  - Sequence for M = 3: 0,1,2,3,2,1,0,1…; period is 2M steps.
  - M = 1: Count alternates 0,1; the top step (Count = 1, Dir = 0) goes straight to Count = 0 with Wrap and Dir stays 0.
  - M = 0: Count stays 0 and Wrap pulses on every step.
  - Done stays 0.
- Shadow reload at Wrap:
  - New MaxCount, Mode and Prescale take effect from the next period.
  - Count is 0 at every reload, so a smaller new M can never leave Count above M.
  - A Mode change applied at reload starts the new mode from Count = 0 and Dir = 0.
- Input changes between reloads (MaxCount, Mode, Prescale) have no effect while Enable = 1.

Test Plan:
- Reset, then Enable = 1, Mode = 0, M = 5, Prescale = 0 -> Count 0,1,2,3,4; Done rises on the 5th step and holds; Enable = 0 -> Done and Count are 0 on the next edge.
- Mode = 1, M = 4, Prescale = 2 -> Tick every 3 cycles; Count 0,1,2,3,0; Wrap coincides with each return to 0, every 12 cycles.
- Mode = 2, M = 3 -> Count 0,1,2,3,2,1,0; Dir = 1 while at 2,1; Wrap once per 6 steps; repeat with M = 1 and M = 0 at the boundaries.
- Mode = 1, M = 8, change MaxCount to 3 mid-period -> the current period completes at 7, then period 3 (0,1,2); changing Mode to 2 at the same point switches to up/down only after that Wrap.
- Assert MResetN low mid-count, asynchronously between edges -> all outputs are 0 immediately; after release with Enable = 1, counting restarts from 0 with freshly loaded shadows.
- Mode = 0 with M = 0 and with M = 1 -> Done on the first step and Count stays 0; Mode = 3 with M = 2 -> identical to Mode 1.
